pe_out_requant_pack: RTL and testbench

- Downstream consumer of the 8-element PE result stream (32-bit signed `out_sum` with single-cycle `valid_out` strobes).
- Requantizes each accumulated sum to an unsigned 8-bit activation: bias add, fixed-point scale, arithmetic shift, clamp.
- Packs four consecutive activations into one 32-bit word and buffers the words in a small FIFO.
- Drives the output buffer over a valid/ready handshake. The PE has no stall input, so all backpressure is absorbed here.

---
 rtl/pe_out_requant_pack.sv | 201 ++++++++++++++++++++
 tb/tb_pe_out_requant_pack.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_out_requant_pack.sv
// rtl/pe_out_requant_pack.sv - requantize PE sums to 8-bit activations, pack 4 per word, buffer in a FIFO (option: REQUANT_ROUND_EN)
module pe_out_requant_pack #(
    parameter int IN_BITS    = 32,
    parameter int ACT_BITS   = 8,
    parameter int PACK_NUM   = 4,
    parameter int MULT_BITS  = 16,
    parameter int SHIFT_BITS = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sum_valid,
    input  logic [IN_BITS-1:0]                sum_data,
    input  logic                              sum_last,
    input  logic [IN_BITS-1:0]                cfg_bias,
    input  logic [MULT_BITS-1:0]              cfg_mult,
    input  logic [SHIFT_BITS-1:0]             cfg_shift,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [ACT_BITS*PACK_NUM-1:0]      m_data,
    output logic [PACK_NUM-1:0]               m_keep,
    output logic                              m_last,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

    localparam int A_W   = IN_BITS + 1;
    localparam int P_W   = A_W + MULT_BITS + 1;
    localparam int W_W   = ACT_BITS * PACK_NUM;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

    // pipeline registers
    logic                       r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic                       r_s1_last,  r_s2_last,  r_s3_last,  r_s4_last;
    logic signed [A_W-1:0]      r_s1_a;
    logic signed [P_W-1:0]      r_s2_p;
    logic signed [P_W-1:0]      r_s3_r;
    logic [ACT_BITS-1:0]        r_s4_q;

    // packer state
    logic [IDX_W-1:0]           r_idx;
    logic [W_W-1:0]             r_lanes;
    logic [PACK_NUM-1:0]        r_keep;

    // FIFO state
    logic [W_W-1:0]             r_mem_data [FIFO_DEPTH];
    logic [PACK_NUM-1:0]        r_mem_keep [FIFO_DEPTH];
    logic                       r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_overflow;

    logic signed [P_W-1:0]      w_a_ext, w_m_ext, w_rnd, w_sum3;
    logic [ACT_BITS-1:0]        w_clamp;
    logic [W_W-1:0]             w_lanes;
    logic [PACK_NUM-1:0]        w_keep;
    logic                       w_push, w_pop, w_wr;

    assign w_a_ext = P_W'(r_s1_a);
    assign w_m_ext = $signed(P_W'({1'b0, cfg_mult}));
    assign w_sum3  = r_s2_p + w_rnd;

`ifdef REQUANT_ROUND_EN
    // round half up: add half an LSB of the shifted result before shifting
    always_comb begin
        w_rnd = '0;
        if (cfg_shift != '0) begin
            w_rnd[cfg_shift - 1'b1] = 1'b1;
        end
    end
`else
    // plain arithmetic shift truncates toward negative infinity
    always_comb begin
        w_rnd = '0;
    end
`endif

    // saturate the shifted value into the unsigned activation range
    always_comb begin
        w_clamp = r_s3_r[ACT_BITS-1:0];
        if (r_s3_r[P_W-1]) begin
            w_clamp = '0;
        end else if (|r_s3_r[P_W-2:ACT_BITS]) begin
            w_clamp = '1;
        end
    end

    // four-stage arithmetic pipeline; valid/last ride alongside the data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s4_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s2_p     <= '0;
            r_s3_r     <= '0;
            r_s4_q     <= '0;
        end else begin
            r_s1_valid <= sum_valid;
            r_s1_last  <= sum_valid & sum_last;
            r_s1_a     <= $signed({sum_data[IN_BITS-1], sum_data}) + $signed({cfg_bias[IN_BITS-1], cfg_bias});
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_p     <= w_a_ext * w_m_ext;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_r     <= w_sum3 >>> cfg_shift;
            r_s4_valid <= r_s3_valid;
            r_s4_last  <= r_s3_last;
            r_s4_q     <= w_clamp;
        end
    end

    // merge the incoming byte into the current word and decide whether it is complete
    always_comb begin
        w_lanes = r_lanes;
        w_keep  = r_keep;
        w_push  = 1'b0;
        if (r_s4_valid) begin
            for (int i = 0; i < PACK_NUM; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_lanes[i*ACT_BITS +: ACT_BITS] = r_s4_q;
                    w_keep[i] = 1'b1;
                end
            end
            w_push = (r_idx == IDX_W'(PACK_NUM - 1)) || r_s4_last;
        end
    end

    // packer restarts at lane 0 after every push, accepted or dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_lanes <= '0;
            r_keep  <= '0;
        end else if (r_s4_valid) begin
            if (w_push) begin
                r_idx   <= '0;
                r_lanes <= '0;
                r_keep  <= '0;
            end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_lanes <= w_lanes;
                r_keep  <= w_keep;
            end
        end
    end

    // a full FIFO still takes a word if the head leaves in the same cycle
    assign w_pop = (r_count != '0) && m_ready;
    assign w_wr  = w_push && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);

    // FIFO storage needs no reset; contents are only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= w_lanes;
            r_mem_keep[r_wr_ptr] <= w_keep;
            r_mem_last[r_wr_ptr] <= r_s4_last;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_valid    = (r_count != '0);
    assign m_data     = m_valid ? r_mem_data[r_rd_ptr] : '0;
    assign m_keep     = m_valid ? r_mem_keep[r_rd_ptr] : '0;
    assign m_last     = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_pe_out_requant_pack.sv
// tb/tb_pe_out_requant_pack.sv - self-checking bench for pe_out_requant_pack
module tb_pe_out_requant_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        sum_valid;
    logic [31:0] sum_data;
    logic        sum_last;
    logic [31:0] bias;
    logic [15:0] mult;
    logic [4:0]  shift;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        overflow;
    logic [3:0]  fifo_count;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  cur_bytes [$];
    logic [36:0] exp_q [$];
    logic        exp_ovf;
    logic [31:0] first_data;
    logic [3:0]  first_keep;
    logic        first_last;

    pe_out_requant_pack dut (
        .clk        (clk),
        .reset      (reset),
        .sum_valid  (sum_valid),
        .sum_data   (sum_data),
        .sum_last   (sum_last),
        .cfg_bias   (bias),
        .cfg_mult   (mult),
        .cfg_shift  (shift),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference requantization using floor division on plain integers
    function automatic logic [7:0] ref_byte(input logic [31:0] v);
        longint x, d, q;
        x = (longint'($signed(v)) + longint'($signed(bias))) * longint'(mult);
        d = 1;
        d = d << shift;
`ifdef REQUANT_ROUND_EN
        if (shift != 0) x = x + d / 2;
`endif
        q = x / d;
        if (x < 0 && q * d != x) q = q - 1;
        if (q < 0) return 8'd0;
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    // reference packer + FIFO (only used while m_ready is held low)
    task automatic model_byte(input logic [31:0] v, input bit last);
        logic [31:0] d;
        logic [3:0]  k;
        cur_bytes.push_back(ref_byte(v));
        if (cur_bytes.size() == 4 || last) begin
            d = '0;
            k = '0;
            for (int i = 0; i < cur_bytes.size(); i++) begin
                d[8*i +: 8] = cur_bytes[i];
                k[i] = 1'b1;
            end
            if (exp_q.size() < 8) exp_q.push_back({last, k, d});
            else exp_ovf = 1'b1;
            cur_bytes.delete();
        end
    endtask

    task automatic send(input logic [31:0] v, input bit last);
        sum_valid = 1'b1;
        sum_data  = v;
        sum_last  = last;
        model_byte(v, last);
        @(negedge clk);
        sum_valid = 1'b0;
        sum_last  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic [36:0] e;
        int n;
        bit first;
        first = 1'b1;
        n = 0;
        m_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            if (m_valid) begin
                e = exp_q.pop_front();
                if (first) begin
                    first_data = m_data;
                    first_keep = m_keep;
                    first_last = m_last;
                    first = 1'b0;
                end
                check({tag, "_data"}, m_data, e[31:0]);
                check({tag, "_keep"}, m_keep, e[35:32]);
                check({tag, "_last"}, m_last, e[36]);
            end
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        check({tag, "_timeout"}, exp_q.size(), 0);
        check({tag, "_empty_valid"}, m_valid, 1'b0);
        check({tag, "_empty_count"}, fifo_count, 4'd0);
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [15:0] m, input logic [4:0] s);
        bias  = b;
        mult  = m;
        shift = s;
    endtask

    initial begin
        int k;
        int n;
        bit last;
        logic [31:0] v;

        reset = 1'b1; sum_valid = 1'b0; sum_data = '0; sum_last = 1'b0;
        m_ready = 1'b0; exp_ovf = 1'b0;
        set_cfg(32'd0, 16'd1, 5'd0);
        wait_cycles(3);
        reset = 1'b0;
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 32'd0);
        check("rst_keep", m_keep, 4'd0);
        check("rst_last", m_last, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_count", fifo_count, 4'd0);

        // rounding + latency
        set_cfg(32'd0, 16'd1, 5'd1);
        send(32'd101, 1'b0);
        send(32'd100, 1'b0);
        send(-32'sd3, 1'b0);
        send(32'd7, 1'b0);
        k = 1;
        while (!m_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 5);
        drain("round");
`ifdef REQUANT_ROUND_EN
        check("round_word", first_data, 32'h04003233);
`else
        check("round_word", first_data, 32'h03003232);
`endif
        check("round_keep", first_keep, 4'hF);

        // saturation
        set_cfg(32'd24, 16'd1, 5'd2);
        send(32'd1000, 1'b0);
        send(-32'sd500, 1'b0);
        send(32'h7FFFFFFF, 1'b0);
        send(32'd4, 1'b0);
        wait_cycles(6);
        drain("sat");
        check("sat_word", first_data, 32'h07FF00FF);

        // scale with negative bias
        set_cfg(-32'sd10, 16'd3, 5'd0);
        send(32'd20, 1'b0);
        send(32'd50, 1'b0);
        send(32'd95, 1'b0);
        send(32'd10, 1'b0);
        wait_cycles(6);
        drain("scale");
        check("scale_word", first_data, 32'h00FF781E);

        // partial flush, then the next sum starts at lane 0
        set_cfg(32'd0, 16'd1, 5'd0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        wait_cycles(6);
        drain("partial");
        check("partial_word", first_data, 32'h00030201);
        check("partial_keep", first_keep, 4'b0111);
        check("partial_last", first_last, 1'b1);
        send(32'd9, 1'b1);
        wait_cycles(6);
        drain("lane0");
        check("lane0_word", first_data, 32'h00000009);
        check("lane0_keep", first_keep, 4'b0001);

        // randomized batches, each ends on a last so the packer is empty afterwards
        for (int b = 0; b < 12; b++) begin
            if ($urandom_range(0, 3) == 0) set_cfg($urandom(), 16'($urandom()), 5'($urandom_range(0, 31)));
            else set_cfg(32'($urandom_range(0, 2000)) - 32'd1000, 16'($urandom_range(0, 600)), 5'($urandom_range(0, 12)));
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) v = $urandom();
                else v = 32'($urandom_range(0, 6000)) - 32'd3000;
                last = (i == n - 1) || ($urandom_range(0, 5) == 0);
                send(v, last);
            end
            wait_cycles(6);
            drain("rand");
        end

        // backpressure and overflow
        set_cfg(32'd0, 16'd1, 5'd0);
        for (int i = 0; i < 32; i++) send(32'(i + 1), 1'b0);
        wait_cycles(6);
        check("bp_count8", fifo_count, 4'd8);
        check("bp_ovf_before", overflow, 1'b0);
        for (int i = 32; i < 36; i++) send(32'(i + 1), 1'b0);
        wait_cycles(6);
        check("bp_count_full", fifo_count, 4'd8);
        check("bp_ovf_after", overflow, exp_ovf);
        check("bp_ovf_set", overflow, 1'b1);
        drain("bp");
        check("bp_first_word", first_data, 32'h04030201);
        check("bp_ovf_held", overflow, 1'b1);

        // reset mid-stream
        send(32'd50, 1'b0);
        send(32'd60, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_bytes.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        check("mrst_count", fifo_count, 4'd0);
        check("mrst_ovf", overflow, 1'b0);
        check("mrst_valid", m_valid, 1'b0);
        check("mrst_data", m_data, 32'd0);
        check("mrst_keep", m_keep, 4'd0);
        check("mrst_last", m_last, 1'b0);
        send(32'd11, 1'b0);
        send(32'd12, 1'b0);
        send(32'd13, 1'b0);
        send(32'd14, 1'b0);
        wait_cycles(6);
        check("mrst_one_word", fifo_count, 4'd1);
        drain("mrst");
        check("mrst_word", first_data, 32'h0E0D0C0B);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
